// File: rtl/rom_dl_pkg.sv
// Shared types, helpers and the default board map for the ROM download router.
package rom_dl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE
    } dl_state_e;

    localparam int DEF_NUM_REGIONS = 17;
    localparam int DEF_ADDR_W      = 25;
    localparam int DEF_LOC_AW      = 13;

    function automatic logic [31:0] region_size(input logic [4:0] aw);
        return 32'd1 << aw;
    endfunction

    // Twelve 8 KiB program/graphics ROMs followed by five 256-byte PROMs.
    function automatic logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] def_base_table();
        logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] t;
        t = '0;
        for (int i = 0; i < DEF_NUM_REGIONS; i++) begin
            if (i < 12)
                t[i*DEF_ADDR_W +: DEF_ADDR_W] = DEF_ADDR_W'(i * 32'h2000);
            else
                t[i*DEF_ADDR_W +: DEF_ADDR_W] = DEF_ADDR_W'(32'h18000 + (i - 12) * 32'h100);
        end
        return t;
    endfunction

    function automatic logic [DEF_NUM_REGIONS*5-1:0] def_aw_table();
        logic [DEF_NUM_REGIONS*5-1:0] t;
        t = '0;
        for (int i = 0; i < DEF_NUM_REGIONS; i++) begin
            t[i*5 +: 5] = (i < 12) ? 5'd13 : 5'd8;
        end
        return t;
    endfunction

    localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_BASE = def_base_table();
    localparam logic [DEF_NUM_REGIONS*5-1:0]          DEF_REGION_AW   = def_aw_table();

endpackage

// File: rtl/rom_dl_decode.sv
// Combinational flat-address decoder: region hit, region index and region-local offset.
module rom_dl_decode
    import rom_dl_pkg::*;
#(
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LOC_AW      = DEF_LOC_AW,
    parameter int IDX_W       = $clog2(DEF_NUM_REGIONS),
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*5-1:0]      REGION_AW   = DEF_REGION_AW
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [LOC_AW-1:0] loc_o
);

    logic [NUM_REGIONS-1:0] hit_vec;
    logic [LOC_AW-1:0]      off_vec [NUM_REGIONS];

    // One extra bit keeps base+size from wrapping for a region at the top of the space.
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        localparam logic [ADDR_W:0] BASE  = {1'b0, REGION_BASE[g*ADDR_W +: ADDR_W]};
        localparam logic [ADDR_W:0] LIMIT = BASE + (ADDR_W+1)'(region_size(REGION_AW[g*5 +: 5]));

        assign hit_vec[g] = ({1'b0, addr_i} >= BASE) && ({1'b0, addr_i} < LIMIT);
        assign off_vec[g] = LOC_AW'(addr_i - BASE[ADDR_W-1:0]);
    end

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        loc_o = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
                loc_o = off_vec[i];
            end
        end
    end

endmodule

// File: rtl/rom_dl_router.sv
// ioctl download router: region decode, registered RAM write port, fill check and load status.
module rom_dl_router
    import rom_dl_pkg::*;
#(
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LOC_AW      = DEF_LOC_AW,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*5-1:0]      REGION_AW   = DEF_REGION_AW
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic                           DL_ACTIVE,
    input  logic                           DL_WR,
    input  logic [ADDR_W-1:0]              DL_ADDR,
    input  logic [7:0]                     DL_DATA,
    output logic [NUM_REGIONS-1:0]         ROM_CS,
    output logic                           ROM_WR,
    output logic [LOC_AW-1:0]              ROM_ADDR,
    output logic [7:0]                     ROM_DATA,
    output logic                           LOADED,
    output logic                           LOAD_ERR,
    output logic [$clog2(NUM_REGIONS)-1:0] ERR_REGION,
    output logic                           OVERRUN,
    output logic [7:0]                     CHECKSUM
);

    localparam int IDX_W = $clog2(NUM_REGIONS);
    localparam int CNT_W = LOC_AW + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    dl_state_e              state_q, state_d;
    logic                   act_q;
    logic [CNT_W-1:0]       cnt_q [NUM_REGIONS];
    logic [CNT_W-1:0]       cnt_d [NUM_REGIONS];
    logic [7:0]             checksum_q, checksum_d;
    logic                   overrun_q, overrun_d;
    logic                   loaded_q, loaded_d;
    logic                   load_err_q, load_err_d;
    logic [IDX_W-1:0]       err_region_q, err_region_d;
    logic                   err_found_q, err_found_d;
    logic [IDX_W-1:0]       scan_q, scan_d;
    logic [NUM_REGIONS-1:0] rom_cs_q, rom_cs_d;
    logic                   rom_wr_q, rom_wr_d;
    logic [LOC_AW-1:0]      rom_addr_q, rom_addr_d;
    logic [7:0]             rom_data_q, rom_data_d;

    logic                   dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic [LOC_AW-1:0]      dec_loc;

    logic                   rise, fall, start_load, fail_now;

    rom_dl_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .LOC_AW      (LOC_AW),
        .IDX_W       (IDX_W),
        .REGION_BASE (REGION_BASE),
        .REGION_AW   (REGION_AW)
    ) u_decode (
        .addr_i (DL_ADDR),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx),
        .loc_o  (dec_loc)
    );

    assign rise     = DL_ACTIVE & ~act_q;
    assign fall     = ~DL_ACTIVE & act_q;
    assign fail_now = cnt_q[scan_q] != CNT_W'(region_size(REGION_AW[int'(scan_q)*5 +: 5]));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        checksum_d   = checksum_q;
        overrun_d    = overrun_q;
        loaded_d     = loaded_q;
        load_err_d   = load_err_q;
        err_region_d = err_region_q;
        err_found_d  = err_found_q;
        scan_d       = scan_q;
        rom_cs_d     = '0;
        rom_wr_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        rom_data_d   = rom_data_q;
        start_load   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                start_load = rise;
            end
            ST_LOAD: begin
                if (DL_WR) begin
                    if (dec_hit) begin
                        rom_cs_d       = NUM_REGIONS'(1) << dec_idx;
                        rom_wr_d       = 1'b1;
                        rom_addr_d     = dec_loc;
                        rom_data_d     = DL_DATA;
                        cnt_d[dec_idx] = sat_inc(cnt_q[dec_idx]);
                        checksum_d     = checksum_q + DL_DATA;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                if (fall) begin
                    state_d     = ST_CHECK;
                    scan_d      = '0;
                    err_found_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (rise) begin
                    start_load = 1'b1;
                end else begin
                    if (fail_now && !err_found_q) begin
                        err_region_d = scan_q;
                    end
                    err_found_d = err_found_q | fail_now;
                    if (scan_q == IDX_W'(NUM_REGIONS - 1)) begin
                        state_d    = ST_DONE;
                        loaded_d   = !(err_found_q || fail_now) && !overrun_q;
                        load_err_d = (err_found_q || fail_now) || overrun_q;
                    end else begin
                        scan_d = scan_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_load) begin
            state_d      = ST_LOAD;
            checksum_d   = '0;
            overrun_d    = 1'b0;
            loaded_d     = 1'b0;
            load_err_d   = 1'b0;
            err_region_d = '0;
            err_found_d  = 1'b0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                cnt_d[i] = '0;
            end
        end
    end

    // act_q comes out of reset high so a DL_ACTIVE still asserted across reset is not a fresh rise.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            act_q        <= 1'b1;
            checksum_q   <= '0;
            overrun_q    <= 1'b0;
            loaded_q     <= 1'b0;
            load_err_q   <= 1'b0;
            err_region_q <= '0;
            err_found_q  <= 1'b0;
            scan_q       <= '0;
            rom_cs_q     <= '0;
            rom_wr_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            act_q        <= DL_ACTIVE;
            checksum_q   <= checksum_d;
            overrun_q    <= overrun_d;
            loaded_q     <= loaded_d;
            load_err_q   <= load_err_d;
            err_region_q <= err_region_d;
            err_found_q  <= err_found_d;
            scan_q       <= scan_d;
            rom_cs_q     <= rom_cs_d;
            rom_wr_q     <= rom_wr_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ROM_CS     = rom_cs_q;
    assign ROM_WR     = rom_wr_q;
    assign ROM_ADDR   = rom_addr_q;
    assign ROM_DATA   = rom_data_q;
    assign LOADED     = loaded_q;
    assign LOAD_ERR   = load_err_q;
    assign ERR_REGION = err_region_q;
    assign OVERRUN    = overrun_q;
    assign CHECKSUM   = checksum_q;

endmodule

// File: tb/tb_rom_dl_router.sv
// Scoreboard bench for rom_dl_router on a scaled-down map of the same shape as the board map.
`timescale 1ns/1ps
module tb_rom_dl_router;

    localparam int NR  = 17;
    localparam int AW  = 25;
    localparam int LAW = 13;
    localparam int IMG = 'h350;

    // 12 regions of 0x40 at 0x000-0x2FF, then 5 regions of 0x10 at 0x300-0x34F.
    function automatic logic [NR*AW-1:0] tb_base();
        logic [NR*AW-1:0] t;
        t = '0;
        for (int i = 0; i < NR; i++) begin
            if (i < 12) t[i*AW +: AW] = AW'(i * 64);
            else        t[i*AW +: AW] = AW'('h300 + (i - 12) * 16);
        end
        return t;
    endfunction

    function automatic logic [NR*5-1:0] tb_aw();
        logic [NR*5-1:0] t;
        t = '0;
        for (int i = 0; i < NR; i++) t[i*5 +: 5] = (i < 12) ? 5'd6 : 5'd4;
        return t;
    endfunction

    localparam logic [NR*AW-1:0] TB_BASE = tb_base();
    localparam logic [NR*5-1:0]  TB_AW   = tb_aw();

    logic           CLK = 1'b0;
    logic           RESET_N;
    logic           DL_ACTIVE;
    logic           DL_WR;
    logic [AW-1:0]  DL_ADDR;
    logic [7:0]     DL_DATA;
    logic [NR-1:0]  ROM_CS;
    logic           ROM_WR;
    logic [LAW-1:0] ROM_ADDR;
    logic [7:0]     ROM_DATA;
    logic           LOADED;
    logic           LOAD_ERR;
    logic [4:0]     ERR_REGION;
    logic           OVERRUN;
    logic [7:0]     CHECKSUM;

    rom_dl_router #(
        .NUM_REGIONS (NR),
        .ADDR_W      (AW),
        .LOC_AW      (LAW),
        .REGION_BASE (TB_BASE),
        .REGION_AW   (TB_AW)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .DL_ACTIVE  (DL_ACTIVE),
        .DL_WR      (DL_WR),
        .DL_ADDR    (DL_ADDR),
        .DL_DATA    (DL_DATA),
        .ROM_CS     (ROM_CS),
        .ROM_WR     (ROM_WR),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_DATA   (ROM_DATA),
        .LOADED     (LOADED),
        .LOAD_ERR   (LOAD_ERR),
        .ERR_REGION (ERR_REGION),
        .OVERRUN    (OVERRUN),
        .CHECKSUM   (CHECKSUM)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NR-1:0]  cs;
        logic [LAW-1:0] addr;
        logic [7:0]     data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         loading = 1'b0;
    logic [7:0] exp_sum;
    int         lat;

    function automatic bit model_hit(input logic [AW-1:0] a, output int idx, output int loc);
        int ai;
        ai  = int'(a);
        idx = 0;
        loc = 0;
        if (ai < 'h300) begin
            idx = ai / 64;
            loc = ai % 64;
            return 1'b1;
        end
        if (ai < 'h350) begin
            idx = 12 + (ai - 'h300) / 16;
            loc = (ai - 'h300) % 16;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
        end
    endtask

    task automatic drive(input logic act, input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
        int   idx, loc;
        exp_t e;
        @(posedge CLK);
        #1;
        DL_ACTIVE = act;
        DL_WR     = wr;
        DL_ADDR   = a;
        DL_DATA   = d;
        if (wr && loading && model_hit(a, idx, loc)) begin
            e.cs   = NR'(1) << idx;
            e.addr = LAW'(loc);
            e.data = d;
            exp_q.push_back(e);
            exp_sum = exp_sum + d;
        end
    endtask

    // One download: rise, bytes 0..n_bytes-1 (dup written twice), optional out-of-map byte, fall.
    task automatic run_dl(input int n_bytes, input int dup, input bit extra, input bit last_on_fall,
                          input logic [7:0] seed);
        logic [AW-1:0] q[$];
        logic [AW-1:0] a;
        for (int i = 0; i < n_bytes; i++) begin
            q.push_back(AW'(i));
            if (i == dup) q.push_back(AW'(i));
        end
        if (extra) q.push_back(AW'(IMG));
        exp_sum = 8'h00;
        drive(1'b1, 1'b0, '0, 8'h00);
        loading = 1'b1;
        for (int k = 0; k < q.size(); k++) begin
            a = q[k];
            if (last_on_fall && k == q.size() - 1) drive(1'b0, 1'b1, a, a[7:0] ^ seed);
            else                                   drive(1'b1, 1'b1, a, a[7:0] ^ seed);
        end
        if (!last_on_fall) drive(1'b0, 1'b0, '0, 8'h00);
        loading = 1'b0;
    endtask

    task automatic wait_status(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge CLK);
            #1;
            n++;
            if (LOADED || LOAD_ERR) break;
        end
    endtask

    task automatic end_of_test(input string nm);
        chk({nm, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge CLK) begin
        if (RESET_N) begin
            n_cmp++;
            if (ROM_WR) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got cs=%h addr=%h data=%h, expected no write",
                             ROM_CS, ROM_ADDR, ROM_DATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({ROM_CS, ROM_ADDR, ROM_DATA} !== mon_e) begin
                        n_bad++;
                        $display("FAIL rom_write: got cs=%h addr=%h data=%h, expected cs=%h addr=%h data=%h",
                                 ROM_CS, ROM_ADDR, ROM_DATA, mon_e.cs, mon_e.addr, mon_e.data);
                    end
                end
            end else if (ROM_CS !== '0) begin
                n_bad++;
                $display("FAIL cs_without_wr: got cs=%h, expected 0", ROM_CS);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N   = 1'b0;
        DL_ACTIVE = 1'b0;
        DL_WR     = 1'b0;
        DL_ADDR   = '0;
        DL_DATA   = 8'h00;
        exp_sum   = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_status", {LOADED, LOAD_ERR, OVERRUN, ERR_REGION, CHECKSUM}, 0);
        chk("reset_rom_port", {ROM_WR, ROM_CS}, 0);
        RESET_N = 1'b1;

        // Full image, data = addr[7:0]; region 13 offset 5 sits at 0x315.
        run_dl(IMG, -1, 1'b0, 1'b0, 8'h00);
        wait_status(lat);
        chk("t1_latency", lat, 18);
        chk("t1_loaded", {LOADED, LOAD_ERR, OVERRUN}, 3'b100);
        chk("t1_err_region", ERR_REGION, 0);
        chk("t1_checksum_hand", CHECKSUM, 8'hD8);
        chk("t1_checksum_model", CHECKSUM, exp_sum);
        end_of_test("t1");

        // Truncated: last region only half filled.
        run_dl('h348, -1, 1'b0, 1'b0, 8'h5A);
        wait_status(lat);
        chk("t2_status", {LOADED, LOAD_ERR, OVERRUN}, 3'b010);
        chk("t2_err_region", ERR_REGION, 16);
        chk("t2_checksum", CHECKSUM, exp_sum);
        end_of_test("t2");

        // One byte past the map.
        run_dl(IMG, -1, 1'b1, 1'b0, 8'hC3);
        wait_status(lat);
        chk("t3_status", {LOADED, LOAD_ERR, OVERRUN}, 3'b011);
        chk("t3_err_region", ERR_REGION, 0);
        chk("t3_checksum", CHECKSUM, exp_sum);
        end_of_test("t3");

        // First byte of region 1 written twice.
        run_dl(IMG, 'h40, 1'b0, 1'b0, 8'h11);
        wait_status(lat);
        chk("t4_status", {LOADED, LOAD_ERR, OVERRUN}, 3'b010);
        chk("t4_err_region", ERR_REGION, 1);
        chk("t4_checksum", CHECKSUM, exp_sum);
        end_of_test("t4");

        // Final byte coincides with the DL_ACTIVE fall.
        run_dl(IMG, -1, 1'b0, 1'b1, 8'h77);
        wait_status(lat);
        chk("t5_latency", lat, 18);
        chk("t5_status", {LOADED, LOAD_ERR, OVERRUN}, 3'b100);
        chk("t5_checksum", CHECKSUM, exp_sum);
        end_of_test("t5");

        // Reset part-way through a download, then stray bytes with DL_ACTIVE still high.
        exp_sum = 8'h00;
        drive(1'b1, 1'b0, '0, 8'h00);
        loading = 1'b1;
        for (int i = 0; i < 'h100; i++) drive(1'b1, 1'b1, AW'(i), 8'(i) ^ 8'h3C);
        @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        loading = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_async_reset_port", {ROM_WR, ROM_CS, ROM_ADDR, ROM_DATA}, 0);
        chk("t6_async_reset_status", {LOADED, LOAD_ERR, OVERRUN, ERR_REGION, CHECKSUM}, 0);
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, AW'(i), 8'hE0 + 8'(i));
        repeat (3) drive(1'b0, 1'b0, '0, 8'h00);
        chk("t6_ignored_after_reset", {LOADED, LOAD_ERR, OVERRUN, CHECKSUM}, 0);
        run_dl(IMG, -1, 1'b0, 1'b0, 8'h3C);
        wait_status(lat);
        chk("t6_reload_status", {LOADED, LOAD_ERR, OVERRUN}, 3'b100);
        chk("t6_reload_checksum", CHECKSUM, exp_sum);
        end_of_test("t6");

        // Overrunning download aborted 5 cycles into the scan by a new rise.
        run_dl(IMG, -1, 1'b1, 1'b0, 8'hA5);
        repeat (5) drive(1'b0, 1'b0, '0, 8'h00);
        run_dl(IMG, -1, 1'b0, 1'b0, 8'h96);
        wait_status(lat);
        chk("t7_latency", lat, 18);
        chk("t7_status", {LOADED, LOAD_ERR, OVERRUN}, 3'b100);
        chk("t7_checksum", CHECKSUM, exp_sum);
        end_of_test("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
